// File: rtl/mem_cache_ctrl_if.sv
// Bus between the MEM stage, the data cache and the SRAM controller.
//
// Handshake: the pipeline raises MEM_R_EN or MEM_W_EN together with ALU_Res
// (and Val_Rm for stores) and holds all of them stable for as long as ready
// is 0. The access completes in the cycle where ready is 1; loads take DATA
// from that same cycle. On the SRAM side, sram_rd_en/sram_wr_en stay high
// with a stable sram_addr/sram_wdata until the controller answers with
// sram_ready=1 for one cycle. Read data must be valid on sram_rdata in that
// cycle. The enables drop at the following clock edge.
interface mem_cache_ctrl_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] Val_Rm;
  logic [31:0] DATA;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  // Cache side: consumes pipeline requests and SRAM responses.
  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, sram_rdata, sram_ready,
    output DATA, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata
  );

  // Environment side: pipeline stage plus SRAM controller.
  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, sram_rdata, sram_ready,
    input  DATA, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate data cache with
// one 32-bit word per line and a single LRU bit per set. Read hits answer
// combinationally; read misses and every store go to the SRAM controller
// while ready holds the pipeline frozen.
module mem_cache_ctrl #(
  parameter int SETS        = 64,
  parameter int TAG_W       = 10,
  parameter int ADDR_OFFSET = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_cache_ctrl_if.slave  bus,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = $clog2(SETS);
  localparam int AW    = IDX_W + TAG_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MISS_RD = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;

  logic [1:0] state;
  logic [1:0] next_state;

  // Per-set storage; valid and lru carry reset, tag/data do not need it.
  logic [SETS-1:0]  valid0;
  logic [SETS-1:0]  valid1;
  logic [SETS-1:0]  lru;
  logic [TAG_W-1:0] tag0  [SETS];
  logic [TAG_W-1:0] tag1  [SETS];
  logic [31:0]      data0 [SETS];
  logic [31:0]      data1 [SETS];

  logic [31:0]      off_addr;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_bits;

  logic        hit0;
  logic        hit1;
  logic        hit;
  logic        hit_way;
  logic [31:0] hit_data;
  logic        victim;

  logic        ready_c;
  logic [31:0] data_c;

  logic        rd_req;
  logic        wr_req;
  logic        fill_en;
  logic        wr_upd;
  logic        rd_hit;

  // Byte address minus the data-memory base, then split into word index/tag.
  assign off_addr    = bus.ALU_Res - 32'(ADDR_OFFSET);
  assign idx         = off_addr[IDX_W+1:2];
  assign tag         = off_addr[AW+1:IDX_W+2];
  assign unused_bits = ^{off_addr[31:AW+2], off_addr[1:0]};

  // A store takes priority over a load when both are raised.
  assign wr_req = bus.MEM_W_EN;
  assign rd_req = bus.MEM_R_EN && !bus.MEM_W_EN;

  // Tag compare, hit data select and victim choice for the addressed set.
  always_comb begin
    hit0     = valid0[idx] && (tag0[idx] == tag);
    hit1     = valid1[idx] && (tag1[idx] == tag);
    hit      = hit0 || hit1;
    hit_way  = hit1;
    hit_data = hit1 ? data1[idx] : data0[idx];
    if (!valid0[idx]) begin
      victim = 1'b0;
    end else if (!valid1[idx]) begin
      victim = 1'b1;
    end else begin
      victim = lru[idx];
    end
  end

  // Next state, ready and load data for the pipeline.
  always_comb begin
    next_state = state;
    ready_c    = 1'b1;
    data_c     = 32'd0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          ready_c    = 1'b0;
          next_state = WRITE;
        end else if (rd_req) begin
          if (hit) begin
            data_c = hit_data;
          end else begin
            ready_c    = 1'b0;
            next_state = MISS_RD;
          end
        end
      end
      MISS_RD: begin
        ready_c = bus.sram_ready;
        if (bus.sram_ready) begin
          data_c     = bus.sram_rdata;
          next_state = IDLE;
        end
      end
      WRITE: begin
        ready_c = bus.sram_ready;
        if (bus.sram_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Reset forces the pipeline-facing outputs to idle values without a clock.
  assign bus.ready      = !rst_n || ready_c;
  assign bus.DATA       = rst_n ? data_c : 32'd0;

  // SRAM enables decode straight from the state register.
  assign bus.sram_rd_en = (state == MISS_RD);
  assign bus.sram_wr_en = (state == WRITE);
  assign bus.sram_addr  = bus.ALU_Res;
  assign bus.sram_wdata = bus.Val_Rm;

  assign dbg_state = state;

  assign fill_en = (state == MISS_RD) && bus.sram_ready;
  assign wr_upd  = (state == WRITE) && bus.sram_ready && hit;
  assign rd_hit  = (state == IDLE) && rd_req && hit;

  // State, valid bits and LRU bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      state <= next_state;
      if (fill_en) begin
        if (victim) begin
          valid1[idx] <= 1'b1;
        end else begin
          valid0[idx] <= 1'b1;
        end
        lru[idx] <= ~victim;
      end else if (wr_upd || rd_hit) begin
        lru[idx] <= ~hit_way;
      end
    end
  end

  // Tag and data arrays: refill on a read miss, update on a store hit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (victim) begin
        tag1[idx]  <= tag;
        data1[idx] <= bus.sram_rdata;
      end else begin
        tag0[idx]  <= tag;
        data0[idx] <= bus.sram_rdata;
      end
    end else if (wr_upd) begin
      if (hit_way) begin
        data1[idx] <= bus.Val_Rm;
      end else begin
        data0[idx] <= bus.Val_Rm;
      end
    end
  end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Bench for mem_cache_ctrl: a table of load/store records drives the cache
// against a cycle-accurate SRAM responder, with a scoreboard queue holding
// the load data or store data each access must produce.
module tb_mem_cache_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  mem_cache_ctrl_if bus ();

  mem_cache_ctrl #(.SETS(64), .TAG_W(10), .ADDR_OFFSET(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;    // cycles the SRAM enable stays high, incl. the ready cycle
    logic [31:0] rdata;
    logic        sram;   // 1 = access must go to SRAM, 0 = read hit
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [18];
  logic [31:0] exp_q [$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat,
                              input logic [31:0] rdata, input logic sram,
                              input logic [31:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.lat = lat;
    v.rdata = rdata; v.sram = sram; v.exp = exp;
    return v;
  endfunction

  task automatic pop_check(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL %s: got %h expected <empty queue>", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_ready", {31'd0, bus.ready}, 32'd1);
    check("idle_data", bus.DATA, 32'd0);
    check("idle_en", {30'd0, bus.sram_rd_en, bus.sram_wr_en}, 32'd0);
  endtask

  // Drive one access; for SRAM accesses play the controller for v.lat cycles.
  task automatic run_vec(input vec_t v);
    logic is_read;
    is_read = v.rd && !v.wr;
    @(posedge clk); #1;
    bus.MEM_R_EN = v.rd;
    bus.MEM_W_EN = v.wr;
    bus.ALU_Res  = v.addr;
    bus.Val_Rm   = v.wdata;
    exp_q.push_back(is_read ? v.exp : v.wdata);
    @(negedge clk);
    if (!v.sram) begin
      check("hit_ready", {31'd0, bus.ready}, 32'd1);
      check("hit_rd_en", {31'd0, bus.sram_rd_en}, 32'd0);
      pop_check("hit_data", bus.DATA);
      @(posedge clk); #1;
    end else begin
      check("decide_ready", {31'd0, bus.ready}, 32'd0);
      check("decide_en", {30'd0, bus.sram_rd_en, bus.sram_wr_en}, 32'd0);
      for (int k = 1; k <= v.lat; k++) begin
        @(posedge clk); #1;
        bus.sram_ready = (k == v.lat);
        bus.sram_rdata = (k == v.lat) ? v.rdata : 32'h0;
        @(negedge clk);
        check("sram_rd_en", {31'd0, bus.sram_rd_en}, {31'd0, is_read});
        check("sram_wr_en", {31'd0, bus.sram_wr_en}, {31'd0, !is_read});
        check("sram_addr", bus.sram_addr, v.addr);
        if (k < v.lat) begin
          check("wait_ready", {31'd0, bus.ready}, 32'd0);
        end else begin
          check("done_ready", {31'd0, bus.ready}, 32'd1);
          if (is_read) pop_check("miss_data", bus.DATA);
          else pop_check("sram_wdata", bus.sram_wdata);
        end
      end
      @(posedge clk); #1;
      bus.sram_ready = 1'b0;
      bus.sram_rdata = 32'h0;
    end
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    idle_check();
  endtask

  // Stimulus table, then hand-written corner cases, then the report.
  initial begin
    vecs[0]  = mk(1, 0, 32'h400, 0, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vecs[1]  = mk(1, 0, 32'h400, 0, 0, 0,            0, 32'hDEADBEEF);
    vecs[2]  = mk(1, 0, 32'h500, 0, 2, 32'h55550500, 1, 32'h55550500);
    vecs[3]  = mk(1, 0, 32'h400, 0, 0, 0,            0, 32'hDEADBEEF);
    vecs[4]  = mk(1, 0, 32'h500, 0, 0, 0,            0, 32'h55550500);
    vecs[5]  = mk(1, 0, 32'h500, 0, 0, 0,            0, 32'h55550500);
    vecs[6]  = mk(1, 0, 32'h600, 0, 3, 32'h66660600, 1, 32'h66660600);
    vecs[7]  = mk(1, 0, 32'h500, 0, 0, 0,            0, 32'h55550500);
    vecs[8]  = mk(1, 0, 32'h600, 0, 0, 0,            0, 32'h66660600);
    vecs[9]  = mk(1, 0, 32'h400, 0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vecs[10] = mk(0, 1, 32'h400, 32'h12345678, 3, 0, 1, 0);
    vecs[11] = mk(1, 0, 32'h400, 0, 0, 0,            0, 32'h12345678);
    vecs[12] = mk(0, 1, 32'h404, 32'hA5A5A5A5, 2, 0, 1, 0);
    vecs[13] = mk(1, 0, 32'h404, 0, 2, 32'hA5A5A5A5, 1, 32'hA5A5A5A5);
    vecs[14] = mk(1, 0, 32'h404, 0, 0, 0,            0, 32'hA5A5A5A5);
    vecs[15] = mk(1, 1, 32'h400, 32'h0BADF00D, 2, 0, 1, 0);
    vecs[16] = mk(1, 0, 32'h400, 0, 0, 0,            0, 32'h0BADF00D);
    vecs[17] = mk(0, 1, 32'h700, 32'hCAFE0700, 1, 0, 1, 0);

    rst_n          = 1'b0;
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.ALU_Res    = 32'h0;
    bus.Val_Rm     = 32'h0;
    bus.sram_rdata = 32'h0;
    bus.sram_ready = 1'b0;
    #2;
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_data", bus.DATA, 32'd0);
    check("rst_en", {30'd0, bus.sram_rd_en, bus.sram_wr_en}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_check();

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // sram_ready while idle must not start or finish anything.
    @(posedge clk); #1;
    bus.sram_ready = 1'b1;
    bus.sram_rdata = 32'hFFFF0000;
    @(negedge clk);
    check("stray_ready", {31'd0, bus.ready}, 32'd1);
    check("stray_data", bus.DATA, 32'd0);
    @(posedge clk); #1;
    bus.sram_ready = 1'b0;
    idle_check();
    run_vec(mk(1, 0, 32'h400, 0, 0, 0, 0, 32'h0BADF00D));

    // Asynchronous reset in the middle of a read miss.
    @(posedge clk); #1;
    bus.MEM_R_EN = 1'b1;
    bus.ALU_Res  = 32'h800;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_rd_en", {31'd0, bus.sram_rd_en}, 32'd1);
    check("pre_rst_ready", {31'd0, bus.ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rd_en", {31'd0, bus.sram_rd_en}, 32'd0);
    check("async_wr_en", {31'd0, bus.sram_wr_en}, 32'd0);
    check("async_ready", {31'd0, bus.ready}, 32'd1);
    check("async_data", bus.DATA, 32'd0);
    bus.MEM_R_EN = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_check();
    run_vec(mk(1, 0, 32'h400, 0, 2, 32'h13572468, 1, 32'h13572468));
    run_vec(mk(1, 0, 32'h400, 0, 0, 0,            0, 32'h13572468));

    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
